multi_event_counter: RTL and testbench
======================================

# multi_event_counter

Downstream consumer of the `multi_top` output stream. It detects rising edges on `O`, counts them over fixed windows of `WINDOW` clock cycles, and emits one saturating count per window through a single-entry VALID/READY output buffer. If a result is still unconsumed when the next window closes, the new result is dropped and flagged.

## Interface
- `WINDOW`, default 16: window length in clock cycles; must be ≥ 2.
- `CW`, default 8: count width; the count saturates at 2^CW−1.

- `CLK`  input  1  clock; all state updates on the rising edge.
- `RST`  input  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `O_IN`  input  1  level from `multi_top` output `O`, synchronous to `CLK`.
- `CLR`  input  1  synchronous clear of the window and the output buffer.
- `READY`  input  1  downstream accepts `COUNT` when `VALID & READY`.
- `COUNT`  output  CW  edge count of the last closed window.
- `SAT`  output  1  `COUNT` saturated; qualified by `VALID`.
- `VALID`  output  1  `COUNT`/`SAT` hold a result.
- `DROP`  output  1  one-cycle pulse when a closed-window result is discarded.

## Operation
- **Edge detect:**
  - `o_d` registers `O_IN`; `rise = O_IN & ~o_d`.
  - `o_d` resets to 0, so `O_IN` already high at reset release counts as one edge.
- **Window counter `win_cnt`:**
  - Counts 0..WINDOW−1 and increments every cycle.
  - At WINDOW−1 it wraps to 0; this is the close cycle.
- **Accumulator `acc` (CW bits) and `sat_acc`:**
  - `acc` increments on `rise`.
  - At 2^CW−1, `acc` holds its value and `sat_acc` is set.
- **Close cycle:**
  - `result = acc + rise`, saturated; `result_sat = sat_acc | overflow`.
  - A rise on the close cycle belongs to the closing window.
  - On the next edge, `acc` and `sat_acc` restart at 0.
- **Output buffer FSM, states EMPTY and FULL (`VALID` = FULL):**
  - EMPTY, close: load `result`, go to FULL.
  - FULL, `READY=1`, no close: go to EMPTY.
  - FULL, `READY=1`, close: load the new result and stay FULL (back-to-back).
  - FULL, `READY=0`, close: keep the old `COUNT`/`SAT`, discard the new result, pulse `DROP` for 1 cycle.
- **`CLR=1`** (priority over everything except `RST`):
  - `win_cnt`, `acc`, `sat_acc` go to 0; the buffer goes to EMPTY; `DROP` = 0.
  - A close coincident with `CLR` is discarded without `DROP`.
  - `o_d` still samples `O_IN`.
- **Reset values:**
  - `COUNT=0`, `SAT=0`, `VALID=0`, `DROP=0`.
  - Internally `win_cnt=0`, `acc=0`, `sat_acc=0`, `o_d=0`.
  - `RST` asserted mid-window discards all partial and buffered state.

## Timing
- `rise` is combinational from `O_IN` and `o_d`; it is counted at the same clock edge.
- **First result:** `VALID` rises after the WINDOW-th rising `CLK` edge following `RST` deassertion; later results follow every WINDOW cycles.
- **Latency:** an edge on the close cycle appears in `COUNT` 1 cycle later. An edge on window cycle 0 appears WINDOW cycles later.
- **Handshake:**
  - Transfer happens on a clock edge with `VALID & READY`.
  - `COUNT`/`SAT` are stable while `VALID & ~READY`.
  - `READY` may be asserted before `VALID`; `VALID` never depends combinationally on `READY`.
- **`DROP`:** registered; high for exactly the cycle after the discarding close edge.
- **Async reset:** outputs go to reset values immediately on `RST` falling, with no clock needed. Counting resumes on the first rising `CLK` edge with `RST=1`.

## Test plan
All scenarios use `WINDOW=16`, `CW=8`, `CLK` period 10 unless stated otherwise.

- **Async reset:** drive `RST=0` at win_cnt=9 while FULL with `COUNT=5` → `COUNT=0`, `VALID=0`, `DROP=0` before the next clock edge; after release the first `VALID` arrives 16 edges later.
- **Alternating input:** `O_IN` toggles every cycle (1,0,1,0…), `READY=1` → `VALID` high 1 cycle every 16, `COUNT=8`, `SAT=0`, no `DROP`.
- **Constant high:** `O_IN` held high from reset → first `COUNT=1`, every later window `COUNT=0`; `O_IN` high only on a close cycle → that window counts +1.
- **Saturation (`CW=2`):** `O_IN` alternating → `COUNT=3`, `SAT=1`; the next window with 2 edges gives `COUNT=2`, `SAT=0`.
- **Backpressure:** `READY=0` for 40 cycles → first `COUNT` held for 2 closes, `DROP` pulses twice (1 cycle each); `READY=1` → one transfer, then the next close loads a fresh value.
- **`CLR` timing:** pulse `CLR` at win_cnt=7 with `acc=3` while FULL → `VALID=0`; the next close is 16 cycles after `CLR` and counts only post-`CLR` edges. `CLR` coincident with a close → no load, no `DROP`.

Source files
------------

// File: rtl/multi_event_counter_if.sv
// Signal bundle between the multi_top output stream consumer and its environment.
// The environment drives the input level, clear and ready. The counter returns the windowed count.
interface multi_event_counter_if #(
  parameter int CW = 8
);
  logic          o_in;
  logic          clr;
  logic          ready;
  logic [CW-1:0] count;
  logic          sat;
  logic          valid;
  logic          drop;

  modport master (
    output o_in, clr, ready,
    input  count, sat, valid, drop
  );

  modport slave (
    input  o_in, clr, ready,
    output count, sat, valid, drop
  );
endinterface

// File: rtl/multi_event_counter.sv
// Counts rising edges of o_in over fixed windows of WINDOW cycles.
// Each window's saturating count goes out through a single-entry valid/ready buffer.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | no result buffered; valid low
//   ST_FULL  | result in count/sat awaiting transfer; valid high
module multi_event_counter #(
  parameter int WINDOW = 16,
  parameter int CW     = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  multi_event_counter_if.slave  evt
);

  localparam int             WCW      = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW - 1);
  localparam logic [CW-1:0]  ACC_MAX  = '1;

  typedef enum logic [0:0] {ST_EMPTY, ST_FULL} state_e;

  state_e         state_q, state_d;
  logic           o_d_q;
  logic [WCW-1:0] win_cnt_q, win_cnt_d;
  logic [CW-1:0]  acc_q, acc_d;
  logic           sat_acc_q, sat_acc_d;
  logic [CW-1:0]  count_q, count_d;
  logic           sat_q, sat_d;
  logic           drop_q, drop_d;

  logic           rise;
  logic           close;
  logic           overflow;
  logic [CW-1:0]  result;
  logic           result_sat;

  // A rise on the close cycle still belongs to the closing window.
  always_comb begin
    rise       = evt.o_in & ~o_d_q;
    close      = (win_cnt_q == WIN_LAST);
    overflow   = rise & (acc_q == ACC_MAX);
    result     = overflow ? ACC_MAX : acc_q + CW'(rise);
    result_sat = sat_acc_q | overflow;
  end

  always_comb begin
    win_cnt_d = win_cnt_q + WCW'(1);
    acc_d     = acc_q;
    sat_acc_d = sat_acc_q;
    if (close) begin
      win_cnt_d = '0;
      acc_d     = '0;
      sat_acc_d = 1'b0;
    end else if (rise) begin
      if (acc_q == ACC_MAX) sat_acc_d = 1'b1;
      else                  acc_d     = acc_q + CW'(1);
    end
    if (evt.clr) begin
      win_cnt_d = '0;
      acc_d     = '0;
      sat_acc_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    sat_d   = sat_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (close) begin
          count_d = result;
          sat_d   = result_sat;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (close) begin
          if (evt.ready) begin
            count_d = result;
            sat_d   = result_sat;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (evt.ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Clear wins over any load or drop, including a coincident close.
    if (evt.clr) begin
      state_d = ST_EMPTY;
      count_d = '0;
      sat_d   = 1'b0;
      drop_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      o_d_q     <= 1'b0;
      win_cnt_q <= '0;
      acc_q     <= '0;
      sat_acc_q <= 1'b0;
      count_q   <= '0;
      sat_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      o_d_q     <= evt.o_in;
      win_cnt_q <= win_cnt_d;
      acc_q     <= acc_d;
      sat_acc_q <= sat_acc_d;
      count_q   <= count_d;
      sat_q     <= sat_d;
      drop_q    <= drop_d;
    end
  end

  assign evt.count = count_q;
  assign evt.sat   = sat_q;
  assign evt.valid = (state_q == ST_FULL);
  assign evt.drop  = drop_q;

endmodule

// File: tb/tb_multi_event_counter.sv
// Drives two counters (CW=8 and CW=2, WINDOW=16) from one stimulus stream.
// Both are checked every cycle against a window/edge-count reference model.
module tb_multi_event_counter;

  localparam int WINDOW = 16;

  logic clk;
  logic rst_n;
  logic o_in, clr, ready;

  multi_event_counter_if #(.CW(8)) if8 ();
  multi_event_counter_if #(.CW(2)) if2 ();

  assign if8.o_in  = o_in;
  assign if8.clr   = clr;
  assign if8.ready = ready;
  assign if2.o_in  = o_in;
  assign if2.clr   = clr;
  assign if2.ready = ready;

  multi_event_counter #(.WINDOW(WINDOW), .CW(8)) dut8 (.clk(clk), .rst_n(rst_n), .evt(if8.slave));
  multi_event_counter #(.WINDOW(WINDOW), .CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .evt(if2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference: cycle position in window, raw (unbounded) edge tally, and buffer contents.
  int m_phase;
  int m_edges;
  bit m_prev;
  int m_max   [2] = '{255, 3};
  bit m_valid [2];
  int m_count [2];
  bit m_sat   [2];
  bit m_drop  [2];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_edges = 0;
    m_prev  = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0;
      m_count[k] = 0;
      m_sat[k]   = 1'b0;
      m_drop[k]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit r;
    int res;
    r      = o_in && !m_prev;
    m_prev = o_in;
    if (clr) begin
      m_phase = 0;
      m_edges = 0;
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 1'b0;
        m_drop[k]  = 1'b0;
      end
      return;
    end
    m_edges += int'(r);
    for (int k = 0; k < 2; k++) begin
      m_drop[k] = 1'b0;
      if (m_phase == WINDOW - 1) begin
        res = (m_edges > m_max[k]) ? m_max[k] : m_edges;
        if (!m_valid[k] || ready) begin
          m_valid[k] = 1'b1;
          m_count[k] = res;
          m_sat[k]   = (m_edges > m_max[k]);
        end else begin
          m_drop[k] = 1'b1;
        end
      end else if (m_valid[k] && ready) begin
        m_valid[k] = 1'b0;
      end
    end
    if (m_phase == WINDOW - 1) begin
      m_phase = 0;
      m_edges = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic check_outputs();
    chk_eq("valid8", 32'(if8.valid), 32'(m_valid[0]));
    chk_eq("drop8",  32'(if8.drop),  32'(m_drop[0]));
    chk_eq("valid2", 32'(if2.valid), 32'(m_valid[1]));
    chk_eq("drop2",  32'(if2.drop),  32'(m_drop[1]));
    if (m_valid[0]) begin
      chk_eq("count8", 32'(if8.count), 32'(m_count[0]));
      chk_eq("sat8",   32'(if8.sat),   32'(m_sat[0]));
    end
    if (m_valid[1]) begin
      chk_eq("count2", 32'(if2.count), 32'(m_count[1]));
      chk_eq("sat2",   32'(if2.sat),   32'(m_sat[1]));
    end
  endtask

  // Called at a falling edge: apply inputs, let one rising edge pass, check at the next falling edge.
  task automatic run_cycle(input bit o, input bit c, input bit r);
    o_in  = o;
    clr   = c;
    ready = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk_eq({tag, "_count8"}, 32'(if8.count), 32'd0);
    chk_eq({tag, "_sat8"},   32'(if8.sat),   32'd0);
    chk_eq({tag, "_valid8"}, 32'(if8.valid), 32'd0);
    chk_eq({tag, "_drop8"},  32'(if8.drop),  32'd0);
    chk_eq({tag, "_count2"}, 32'(if2.count), 32'd0);
    chk_eq({tag, "_valid2"}, 32'(if2.valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    o_in  = 1'b0;
    clr   = 1'b0;
    ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Alternating input, always ready: 8 edges per window, CW=2 saturates.
    for (int i = 0; i < 4 * WINDOW; i++) run_cycle(i[0] == 1'b0, 1'b0, 1'b1);

    // Random input and ready, occasional clear.
    for (int i = 0; i < 1500; i++)
      run_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0);

    // Backpressure for 40 cycles, then drain.
    for (int i = 0; i < 40; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, i > 3);

    // Clear mid-window while full.
    for (int i = 0; i < 30; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < WINDOW && m_phase != 7; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * WINDOW; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // Clear coincident with a close: no load and no drop.
    for (int i = 0; i < 20; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    for (int i = 0; i < WINDOW && m_phase != WINDOW - 1; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    run_cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2 * WINDOW; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b1);

    // Async reset while full: outputs clear with no clock edge.
    for (int i = 0; i < 25; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk_eq("pre_arst_valid8", 32'(if8.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("arst");
    o_in = 1'b1;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;

    // Constant high from release: one edge in the first window, none after.
    for (int i = 0; i < 3 * WINDOW; i++) run_cycle(1'b1, 1'b0, 1'b1);
    // High only on a close cycle: that window counts one edge.
    for (int i = 0; i < WINDOW && m_phase != 0; i++) run_cycle(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * WINDOW; i++) run_cycle(m_phase == WINDOW - 1, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++)
      run_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
